// File: rtl/tc_bank.sv
// Timer/counter bank: NUM_CH uniform channels, each runtime-configurable as TON, TOF, TP or CTU,
// sharing one timebase prescaler and a single config write port.
module tc_bank #(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned CH_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_in,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [1:0]        wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  rd_acc,
  output logic [NUM_CH-1:0] done,
  output logic              tick
);

  typedef enum logic [1:0] {MODE_TON, MODE_TOF, MODE_TP, MODE_CTU} mode_t;
  typedef enum logic [1:0] {REG_PRESET, REG_CTRL, REG_CLEAR, REG_NOP} reg_t;

  localparam int unsigned   PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]     preCnt;
  logic [NUM_CH-1:0] inD, rise, en, enNext, doneNext;
  logic [CNT_W-1:0]  acc [NUM_CH];
  logic [CNT_W-1:0]  accNext [NUM_CH];
  logic [CNT_W-1:0]  preset [NUM_CH];
  logic [CNT_W-1:0]  presetNext [NUM_CH];
  mode_t             mode [NUM_CH];
  mode_t             modeNext [NUM_CH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preCnt <= '0;
      tick   <= 1'b0;
    end else begin
      tick   <= (preCnt == PLAST);
      preCnt <= (preCnt == PLAST) ? '0 : preCnt + 1'b1;
    end
  end

  // inD tracks ch_in regardless of en, so re-enabling never sees a stale edge
  assign rise = ch_in & ~inD;

  always_comb begin
    enNext   = en;
    doneNext = done;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      accNext[i]    = acc[i];
      presetNext[i] = preset[i];
      modeNext[i]   = mode[i];
      if (en[i]) begin
        unique case (mode[i])
          MODE_TON: begin
            if (!ch_in[i]) begin
              accNext[i]  = '0;
              doneNext[i] = 1'b0;
            end else begin
              if (tick && acc[i] < preset[i]) accNext[i] = acc[i] + CNT_W'(1);
              doneNext[i] = (accNext[i] >= preset[i]);
            end
          end
          MODE_TOF: begin
            if (ch_in[i]) begin
              accNext[i]  = '0;
              doneNext[i] = 1'b1;
            end else if (done[i]) begin
              if (tick && acc[i] < preset[i]) accNext[i] = acc[i] + CNT_W'(1);
              if (accNext[i] >= preset[i]) doneNext[i] = 1'b0;
            end
          end
          MODE_TP: begin
            if (!done[i]) begin
              if (rise[i]) begin
                accNext[i]  = '0;
                doneNext[i] = 1'b1;
              end
            end else begin
              if (tick && acc[i] < preset[i]) accNext[i] = acc[i] + CNT_W'(1);
              if (accNext[i] >= preset[i]) doneNext[i] = 1'b0;
            end
          end
          MODE_CTU: begin
            if (rise[i] && acc[i] != '1) accNext[i] = acc[i] + CNT_W'(1);
            doneNext[i] = (accNext[i] >= preset[i]);
          end
        endcase
      end
      // Writes are evaluated last so they override tick/rise updates on the same edge
      if (wr_en && wr_ch == CH_W'(i)) begin
        unique case (reg_t'(wr_addr))
          REG_PRESET: presetNext[i] = wr_data;
          REG_CTRL: begin
            modeNext[i] = mode_t'(wr_data[1:0]);
            enNext[i]   = wr_data[2];
            accNext[i]  = '0;
            doneNext[i] = 1'b0;
          end
          REG_CLEAR: begin
            accNext[i]  = '0;
            doneNext[i] = 1'b0;
          end
          REG_NOP: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inD  <= '0;
      en   <= '0;
      done <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc[i]    <= '0;
        preset[i] <= '0;
        mode[i]   <= MODE_TON;
      end
    end else begin
      inD  <= ch_in;
      en   <= enNext;
      done <= doneNext;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc[i]    <= accNext[i];
        preset[i] <= presetNext[i];
        mode[i]   <= modeNext[i];
      end
    end
  end

  always_comb begin
    rd_acc = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) rd_acc = acc[i];
    end
  end

endmodule

// File: tb/tb_tc_bank.sv
// Directed bench for tc_bank: main instance (TICK_DIV=4, CNT_W=16, 8 channels) plus a
// small instance (TICK_DIV=1, CNT_W=4, 3 channels) for saturation and out-of-range addressing.
module tb_tc_bank;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic [7:0]  chIn = '0;
  logic        wrEn = 1'b0;
  logic [2:0]  wrCh = '0;
  logic [1:0]  wrAddr = '0;
  logic [15:0] wrData = '0;
  logic [2:0]  rdCh = '0;
  logic [15:0] rdAcc;
  logic [7:0]  done;
  logic        tick;

  logic [2:0]  chIn2 = '0;
  logic        wrEn2 = 1'b0;
  logic [1:0]  wrCh2 = '0;
  logic [1:0]  wrAddr2 = '0;
  logic [3:0]  wrData2 = '0;
  logic [1:0]  rdCh2 = '0;
  logic [3:0]  rdAcc2;
  logic [2:0]  done2;
  logic        tick2;

  int checks = 0;
  int errors = 0;
  int edges = 0;
  int ticks;
  bit t;

  typedef struct {
    logic        chIn;
    logic        wrEn;
    logic [1:0]  wrAddr;
    logic [15:0] wrData;
    logic        expDone;
    logic [15:0] expAcc;
  } vec_t;
  vec_t vecs [19];

  tc_bank #(.NUM_CH(8), .CNT_W(16), .TICK_DIV(4), .CH_W(3)) dut (
    .clk(clk), .reset(rstN), .ch_in(chIn), .wr_en(wrEn), .wr_ch(wrCh), .wr_addr(wrAddr),
    .wr_data(wrData), .rd_ch(rdCh), .rd_acc(rdAcc), .done(done), .tick(tick)
  );

  tc_bank #(.NUM_CH(3), .CNT_W(4), .TICK_DIV(1), .CH_W(2)) dut2 (
    .clk(clk), .reset(rstN), .ch_in(chIn2), .wr_en(wrEn2), .wr_ch(wrCh2), .wr_addr(wrAddr2),
    .wr_data(wrData2), .rd_ch(rdCh2), .rd_acc(rdAcc2), .done(done2), .tick(tick2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic bit expTickAfter(input int n);
    return (n > 0) && (n % 4 == 0);
  endfunction

  task automatic step();
    @(posedge clk);
    edges++;
    #1;
    chk("tick", tick, expTickAfter(edges));
  endtask

  task automatic wr(input int ch, input int addr, input int data);
    wrEn = 1'b1; wrCh = 3'(ch); wrAddr = 2'(addr); wrData = 16'(data);
    step();
    wrEn = 1'b0;
  endtask

  task automatic wr2(input int ch, input int addr, input int data);
    wrEn2 = 1'b1; wrCh2 = 2'(ch); wrAddr2 = 2'(addr); wrData2 = 4'(data);
    step();
    wrEn2 = 1'b0;
  endtask

  task automatic setVec(input int i, input bit ci, input bit we, input int wa, input int wd,
                        input bit ed, input int ea);
    vecs[i].chIn = ci;  vecs[i].wrEn = we; vecs[i].wrAddr = 2'(wa);
    vecs[i].wrData = 16'(wd); vecs[i].expDone = ed; vecs[i].expAcc = 16'(ea);
  endtask

  initial begin
    // CTU channel 1, preset 5: rises at rows 0,2,5,7,9; preset/clear/ctrl writes afterwards
    setVec(0,  1, 0, 0, 0, 0, 1);
    setVec(1,  0, 0, 0, 0, 0, 1);
    setVec(2,  1, 0, 0, 0, 0, 2);
    setVec(3,  1, 0, 0, 0, 0, 2);
    setVec(4,  0, 0, 0, 0, 0, 2);
    setVec(5,  1, 0, 0, 0, 0, 3);
    setVec(6,  0, 0, 0, 0, 0, 3);
    setVec(7,  1, 0, 0, 0, 0, 4);
    setVec(8,  0, 0, 0, 0, 0, 4);
    setVec(9,  1, 0, 0, 0, 1, 5);
    setVec(10, 0, 0, 0, 0, 1, 5);
    setVec(11, 0, 1, 0, 7, 1, 5);
    setVec(12, 0, 0, 0, 0, 0, 5);
    setVec(13, 0, 1, 0, 3, 0, 5);
    setVec(14, 0, 0, 0, 0, 1, 5);
    setVec(15, 1, 1, 2, 0, 0, 0);
    setVec(16, 0, 0, 0, 0, 0, 0);
    setVec(17, 1, 0, 0, 0, 0, 1);
    setVec(18, 0, 1, 1, 7, 0, 0);

    #1 rstN = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_done", done, 0);
    chk("rst_acc", rdAcc, 0);
    chk("rst_tick", tick, 0);
    chk("rst_tick2", tick2, 0);
    chk("rst_acc2", rdAcc2, 0);
    rstN = 1'b1;
    edges = 0;

    // TON ch0, preset 3
    rdCh = 0;
    wr(0, 0, 3);
    wr(0, 1, 4);
    chIn[0] = 1'b1;
    ticks = 0;
    for (int c = 0; c < 40 && ticks < 3; c++) begin
      t = expTickAfter(edges);
      step();
      if (t) ticks++;
      chk("ton_acc", rdAcc, (ticks < 3) ? ticks : 3);
      chk("ton_done", done[0], ticks >= 3);
    end
    chk("ton_ticks", ticks, 3);
    chIn[0] = 1'b0;
    step();
    chk("ton_off_done", done[0], 0);
    chk("ton_off_acc", rdAcc, 0);

    // CTU ch1 table
    rdCh = 1;
    wr(1, 0, 5);
    wr(1, 1, 7);
    for (int i = 0; i < 19; i++) begin
      chIn[1] = vecs[i].chIn;
      wrEn = vecs[i].wrEn; wrCh = 3'd1; wrAddr = vecs[i].wrAddr; wrData = vecs[i].wrData;
      step();
      wrEn = 1'b0;
      chk($sformatf("ctu_done_%0d", i), done[1], vecs[i].expDone);
      chk($sformatf("ctu_acc_%0d", i), rdAcc, vecs[i].expAcc);
    end

    // TP ch2, preset 2, with retriggers mid-pulse
    rdCh = 2;
    wr(2, 0, 2);
    wr(2, 1, 6);
    chIn[2] = 1'b1;
    step();
    chk("tp_start_done", done[2], 1);
    chk("tp_start_acc", rdAcc, 0);
    ticks = 0;
    for (int c = 0; c < 20 && ticks < 2; c++) begin
      t = expTickAfter(edges);
      chIn[2] = ~chIn[2];
      step();
      if (t) ticks++;
      chk("tp_done", done[2], ticks < 2);
      chk("tp_acc", rdAcc, ticks);
    end
    chk("tp_ticks", ticks, 2);
    chIn[2] = 1'b0;
    step();
    chk("tp_end_done", done[2], 0);
    chk("tp_end_acc", rdAcc, 2);
    chIn[2] = 1'b1;
    step();
    chk("tp_restart_done", done[2], 1);
    chk("tp_restart_acc", rdAcc, 0);
    chIn[2] = 1'b0;
    repeat (12) step();
    chk("tp_restart_end_done", done[2], 0);
    chk("tp_restart_end_acc", rdAcc, 2);
    wr(2, 0, 0);
    chIn[2] = 1'b1;
    step();
    chk("tp_p0_high", done[2], 1);
    step();
    chk("tp_p0_low", done[2], 0);
    chIn[2] = 1'b0;

    // TOF ch3, preset 2
    rdCh = 3;
    wr(3, 0, 2);
    wr(3, 1, 5);
    chIn[3] = 1'b1;
    step();
    chk("tof_on_done", done[3], 1);
    chIn[3] = 1'b0;
    ticks = 0;
    for (int c = 0; c < 20 && ticks < 2; c++) begin
      t = expTickAfter(edges);
      step();
      if (t) ticks++;
      chk("tof_done", done[3], ticks < 2);
      chk("tof_acc", rdAcc, ticks);
    end
    chk("tof_ticks", ticks, 2);
    repeat (6) step();
    chk("tof_hold_done", done[3], 0);
    chk("tof_hold_acc", rdAcc, 2);
    chIn[3] = 1'b1;
    step();
    chk("tof_re_done", done[3], 1);
    chk("tof_re_acc", rdAcc, 0);
    chIn[3] = 1'b0;
    ticks = 0;
    for (int c = 0; c < 20 && ticks < 1; c++) begin
      t = expTickAfter(edges);
      step();
      if (t) ticks++;
    end
    chk("tof_mid_acc", rdAcc, 1);
    chk("tof_mid_done", done[3], 1);
    chIn[3] = 1'b1;
    step();
    chk("tof_back_acc", rdAcc, 0);
    chk("tof_back_done", done[3], 1);
    wr(3, 2, 0);
    chk("tof_clr_done", done[3], 0);
    step();
    chk("tof_clr_return", done[3], 1);
    wr(3, 0, 0);
    chIn[3] = 1'b0;
    step();
    chk("tof_p0_done", done[3], 0);

    // Clear on the same edge as a TON tick
    rdCh = 0;
    chIn[0] = 1'b1;
    for (int c = 0; c < 8 && !expTickAfter(edges); c++) step();
    step();
    chk("clr_pre_acc", rdAcc, 1);
    for (int c = 0; c < 8 && !expTickAfter(edges); c++) step();
    wr(0, 2, 0);
    chk("clr_tick_acc", rdAcc, 0);
    chk("clr_tick_done", done[0], 0);

    // en=0 freeze and no spurious edge on re-enable (ch1 CTU, preset 3)
    rdCh = 1;
    wr(1, 1, 3);
    for (int c = 0; c < 5; c++) begin
      chIn[1] = ~chIn[1];
      step();
      chk("frz_acc", rdAcc, 0);
      chk("frz_done", done[1], 0);
    end
    wr(1, 1, 7);
    step();
    chk("reen_acc", rdAcc, 0);
    chIn[1] = 1'b0;
    step();
    chIn[1] = 1'b1;
    step();
    chk("reen_rise_acc", rdAcc, 1);
    wr(3, 1, 1);
    chIn[3] = 1'b1;
    repeat (3) step();
    chk("frz_tof_done", done[3], 0);

    // Small instance: TICK_DIV=1, CNT_W=4
    chk("tick2_every", tick2, 1);
    rdCh2 = 1;
    wr2(1, 0, 3);
    wr2(1, 1, 4);
    chIn2[1] = 1'b1;
    step();
    chk("t1_acc1", rdAcc2, 1);
    chk("t1_tick2", tick2, 1);
    step();
    chk("t1_acc2", rdAcc2, 2);
    chk("t1_done2", done2[1], 0);
    step();
    chk("t1_acc3", rdAcc2, 3);
    chk("t1_done3", done2[1], 1);
    rdCh2 = 0;
    wr2(0, 0, 15);
    wr2(0, 1, 7);
    for (int c = 0; c < 20; c++) begin
      chIn2[0] = 1'b1;
      step();
      chIn2[0] = 1'b0;
      step();
    end
    chk("sat_acc", rdAcc2, 15);
    chk("sat_done", done2[0], 1);
    rdCh2 = 3;
    #1;
    chk("rd_oob", rdAcc2, 0);
    wr2(3, 2, 0);
    wr2(3, 1, 0);
    rdCh2 = 0;
    #1;
    chk("wr_oob_acc", rdAcc2, 15);
    chk("wr_oob_done", done2, 3'b011);

    // Reset mid-count
    wr(3, 1, 5);
    step();
    chk("pre_rst_tof", done[3], 1);
    rdCh = 1;
    #1;
    chk("pre_rst_acc", rdAcc, 1);
    rstN = 1'b0;
    #1;
    chk("async_done", done, 0);
    chk("async_acc", rdAcc, 0);
    chk("async_tick", tick, 0);
    chk("async_done2", done2, 0);
    repeat (2) @(posedge clk);
    #2;
    rstN = 1'b1;
    edges = 0;
    repeat (3) step();
    chk("post_rst_no_tick", tick, 0);
    step();
    chk("post_rst_first_tick", tick, 1);
    chk("post_rst_acc", rdAcc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
